md_issue_ctrl: RTL and testbench

Sequencing stage that sits directly upstream of the `multdiv` unit in the processor's execute stage. It accepts one multiply or divide request from the pipeline and drives `multdiv` operands and a single-cycle start pulse. It stalls the pipeline until `data_resultRDY`, then presents the result, exception flag and destination register to writeback for exactly one cycle.

---
 rtl/md_issue_ctrl_if.sv | 43 ++++
 rtl/md_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: bundles the request, multdiv and writeback signals of
// md_issue_ctrl.
//   slave  - view taken by md_issue_ctrl
//   master - view taken by the surrounding pipeline / multdiv / bench
// Signal groups:
//   req_*  pipeline request (valid/ready handshake) plus flush and stall
//   md_*   operands and start pulses to multdiv, result/ready back from it
//   wb_*   one-cycle writeback strobe with captured result
interface md_issue_ctrl_if;
    logic        req_valid;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        stall;
    logic        flush;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, flush,
        input  md_result, md_exception, md_resultRDY,
        output req_ready, stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        output wb_valid, wb_rd, wb_data, wb_exception
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, flush,
        output md_result, md_exception, md_resultRDY,
        input  req_ready, stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        input  wb_valid, wb_rd, wb_data, wb_exception
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/sequencing stage in front of the multdiv unit.
// Accepts one multiply/divide request, holds operands stable for multdiv,
// fires a single-cycle MULT/DIV start pulse, stalls the pipeline until
// multdiv reports ready, then strobes the captured result to writeback for
// one cycle.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      md_issue_ctrl_if.slave (request, multdiv and writeback groups)
// Parameters:
//   TIMEOUT  WAIT cycle limit, 2..255; only used when MD_TIMEOUT_EN is defined
// Build option:
//   MD_TIMEOUT_EN  adds an 8-bit WAIT counter; on expiry the operation ends
//                  with wb_exception=1, wb_data=0.
module md_issue_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset_n,
    md_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  rd_q, rd_d;
    logic        mult_q, mult_d;
    logic        div_q, div_d;
    logic        stall_q, stall_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_exc_q, wb_exc_d;

`ifdef MD_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  cnt_q, cnt_d;
`else
    // Without the timeout counter TIMEOUT has no effect; this empty block
    // only flags an out-of-range value in elaborated hierarchies.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_out_of_range
    end
`endif

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        rd_d       = rd_q;
        mult_d     = 1'b0;
        div_d      = 1'b0;
        stall_d    = stall_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_exc_d   = wb_exc_q;
`ifdef MD_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                // flush blocks a simultaneous request
                if (bus.req_valid && !bus.flush) begin
                    opa_d   = bus.req_a;
                    opb_d   = bus.req_b;
                    rd_d    = bus.req_rd;
                    // op is consumed directly into the start-pulse flops
                    mult_d  = ~bus.req_op;
                    div_d   = bus.req_op;
                    stall_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                // md_resultRDY may still be high from the previous op: ignore it
                if (bus.flush) begin
                    stall_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
`ifdef MD_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            WAIT: begin
                if (bus.flush) begin
                    stall_d = 1'b0;
                    state_d = IDLE;
                end else if (bus.md_resultRDY) begin
                    wb_data_d  = bus.md_result;
                    wb_exc_d   = bus.md_exception;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end
`ifdef MD_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    wb_data_d  = '0;
                    wb_exc_d   = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                stall_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            rd_q       <= '0;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            stall_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_exc_q   <= 1'b0;
`ifdef MD_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            rd_q       <= rd_d;
            mult_q     <= mult_d;
            div_q      <= div_d;
            stall_q    <= stall_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_exc_q   <= wb_exc_d;
`ifdef MD_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.stall        = stall_q;
    assign bus.md_operandA  = opa_q;
    assign bus.md_operandB  = opb_q;
    assign bus.md_ctrl_MULT = mult_q;
    assign bus.md_ctrl_DIV  = div_q;
    // A flush arriving during DONE must still cancel the strobe in that same
    // cycle, so the registered strobe is gated by the live flush.
    assign bus.wb_valid     = wb_valid_q & ~bus.flush;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_exception = wb_exc_q;
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl with a behavioural multdiv model of
// programmable ready latency (ready sampled L edges after the start-pulse
// edge; L=0 means never ready). Expected results, strobe timing and stall
// length are derived per request from the block's rules.
module tb_md_issue_ctrl;
`ifdef MD_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 64;
    localparam bit TO_EN = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    md_issue_ctrl_if bus();

    md_issue_ctrl #(.TIMEOUT(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // multdiv model
    int mdl_lat = 1;
    int mdl_cnt;
    bit mdl_busy;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mdl_cnt           <= 0;
            mdl_busy          <= 1'b0;
            bus.md_resultRDY  <= 1'b0;
            bus.md_result     <= '0;
            bus.md_exception  <= 1'b0;
        end else if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
            if (bus.md_ctrl_MULT) begin
                bus.md_result    <= bus.md_operandA * bus.md_operandB;
                bus.md_exception <= 1'b0;
            end else if (bus.md_operandB == 0) begin
                bus.md_result    <= '0;
                bus.md_exception <= 1'b1;
            end else begin
                bus.md_result    <= $signed(bus.md_operandA) / $signed(bus.md_operandB);
                bus.md_exception <= 1'b0;
            end
            bus.md_resultRDY <= (mdl_lat == 1);
            mdl_busy         <= (mdl_lat > 1);
            mdl_cnt          <= mdl_lat - 2;
        end else if (mdl_busy) begin
            if (mdl_cnt == 0) begin
                bus.md_resultRDY <= 1'b1;
                mdl_busy         <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // next request presented while the current one is in flight (chain mode)
    bit          nxt_op;
    logic [31:0] nxt_a, nxt_b;
    logic [4:0]  nxt_rd;
    int          last_wait;

    // Issue one request from a negedge and follow it until req_ready returns.
    // flush_at >= 0: pulse flush at that cycle index (0 = START cycle).
    // flush_done: raise flush during the DONE cycle.
    // chain: keep req_valid high and present nxt_* after acceptance.
    task automatic run_op(input string nm, input bit op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input int flush_at,
                          input bit flush_done, input bit chain);
        int wait_cyc = 0, wb_idx = -1, wb_cnt = 0, mult_cnt = 0, div_cnt = 0;
        int stall_cnt = 0, rdy_idx = -1, eff, exp_rdy, exp_wb;
        bit to, ops_ok = 1'b1;
        logic [31:0] got_d = '0, exp_d;
        logic        got_x = 1'b0, exp_x;
        logic [4:0]  got_rd = '0;

        to  = TO_EN && (lat == 0 || lat > TO);
        eff = to ? TO : lat;
        if (to)                      begin exp_d = '0;    exp_x = 1'b1; end
        else if (!op)                begin exp_d = a * b; exp_x = 1'b0; end
        else if (b == 0)             begin exp_d = '0;    exp_x = 1'b1; end
        else begin exp_d = $signed(a) / $signed(b);       exp_x = 1'b0; end
        exp_rdy = (flush_at >= 0) ? flush_at + 1 : eff + 2;
        exp_wb  = (flush_at >= 0 || flush_done) ? 0 : 1;

        mdl_lat       = lat;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
        while (!bus.req_ready && wait_cyc < 100) begin
            @(negedge clock);
            wait_cyc++;
        end
        last_wait = wait_cyc;
        chk({nm, "_accept_bound"}, 32'(wait_cyc < 100), 32'd1);
        @(posedge clock);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (bus.md_ctrl_MULT) mult_cnt++;
            if (bus.md_ctrl_DIV)  div_cnt++;
            if (bus.stall) begin
                stall_cnt++;
                if (bus.md_operandA !== a || bus.md_operandB !== b) ops_ok = 1'b0;
            end
            if (bus.wb_valid) begin
                wb_cnt++;
                wb_idx = i;
                got_d  = bus.wb_data;
                got_x  = bus.wb_exception;
                got_rd = bus.wb_rd;
            end
            bus.flush = 1'b0;
            if (bus.req_ready) begin
                rdy_idx = i;
                break;
            end
            if (i == 0) begin
                if (chain) begin
                    bus.req_op = nxt_op;
                    bus.req_a  = nxt_a;
                    bus.req_b  = nxt_b;
                    bus.req_rd = nxt_rd;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (i == flush_at) bus.flush = 1'b1;
            if (flush_done && i == eff) begin
                @(posedge clock);
                #1 bus.flush = 1'b1;
            end
        end
        chk({nm, "_ready_idx"}, 32'(rdy_idx), 32'(exp_rdy));
        chk({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_rdy));
        chk({nm, "_mult_pulses"}, 32'(mult_cnt), 32'(!op));
        chk({nm, "_div_pulses"}, 32'(div_cnt), 32'(op));
        chk({nm, "_ops_stable"}, 32'(ops_ok), 32'd1);
        chk({nm, "_wb_count"}, 32'(wb_cnt), 32'(exp_wb));
        if (exp_wb == 1) begin
            chk({nm, "_wb_idx"}, 32'(wb_idx), 32'(eff + 1));
            chk({nm, "_wb_data"}, got_d, exp_d);
            chk({nm, "_wb_exc"}, 32'(got_x), 32'(exp_x));
            chk({nm, "_wb_rd"}, 32'(got_rd), 32'(rd));
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_rd    = '0;
        bus.flush     = 1'b0;

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_opA", bus.md_operandA, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // multiply, long latency
        run_op("mul", 1'b0, 32'd6, 32'd7, 5'd11, 33, -1, 1'b0, 1'b0);
        // divide by zero
        run_op("div0", 1'b1, 32'd100, 32'd0, 5'd12, 10, -1, 1'b0, 1'b0);
        // back-to-back with req_valid held
        nxt_op = 1'b1; nxt_a = 32'd20; nxt_b = 32'd4; nxt_rd = 5'd7;
        run_op("b2b1", 1'b0, 32'd3, 32'd5, 5'd6, 4, -1, 1'b0, 1'b1);
        run_op("b2b2", 1'b1, 32'd20, 32'd4, 5'd7, 6, -1, 1'b0, 1'b0);
        chk("b2b2_accept_wait", 32'(last_wait), 32'd0);
        // minimum latency, rd = 0
        run_op("minlat", 1'b0, 32'd9, 32'd9, 5'd0, 1, -1, 1'b0, 1'b0);

        // flush 5 cycles into WAIT; later stale ready must be ignored
        run_op("flw", 1'b0, 32'd8, 32'd8, 5'd3, 12, 6, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            chk("flw_idle_wb", 32'(bus.wb_valid), 32'd0);
            chk("flw_idle_ready", 32'(bus.req_ready), 32'd1);
        end
        // ready still high from the flushed op while START runs
        run_op("stale", 1'b0, 32'd5, 32'd4, 5'd2, 3, -1, 1'b0, 1'b0);
        // flush in START and in DONE
        run_op("fls", 1'b1, 32'd50, 32'd5, 5'd4, 5, 0, 1'b0, 1'b0);
        run_op("fld", 1'b1, 32'd50, 32'd5, 5'd4, 5, -1, 1'b1, 1'b0);

        // randomized requests
        for (int k = 0; k < 12; k++) begin
            bit          rop;
            logic [31:0] ra, rb;
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom & 32'h7fff_ffff;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom | 32'd1);
            run_op("rnd", rop, ra, rb, 5'($urandom), int'($urandom_range(1, 40)), -1, 1'b0, 1'b0);
        end

`ifdef MD_TIMEOUT_EN
        run_op("tout", 1'b0, 32'd9, 32'd9, 5'd3, 0, -1, 1'b0, 1'b0);
        run_op("tout_edge", 1'b0, 32'd9, 32'd9, 5'd3, TO, -1, 1'b0, 1'b0);
`endif

        // async reset during WAIT
        mdl_lat       = 20;
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b1;
        bus.req_a     = 32'd77;
        bus.req_b     = 32'd3;
        bus.req_rd    = 5'd9;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("pre_rst_stall", 32'(bus.stall), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.stall), 32'd0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_ctrl", {30'd0, bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 32'd0);
        chk("arst_opA", bus.md_operandA, 32'd0);
        chk("arst_opB", bus.md_operandB, 32'd0);
        chk("arst_wb_data", bus.wb_data, 32'd0);
        chk("arst_wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("arst_wb_flags", {30'd0, bus.wb_valid, bus.wb_exception}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_op("post_rst", 1'b0, 32'd2, 32'd2, 5'd5, 5, -1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
